// File: rtl/dpe_input_arbiter_if.sv
// dpe_pkg / dpe_if
// Purpose: shared DPE address map and the AXI-Stream interface used between
//          DPE stages.
// Interface ports:
//   clk, rst        - clock and synchronous active-high reset of the stream
//   m_axis modport  - producer side: drives tvalid/tdata/tkeep/tlast/tuser_*,
//                     receives tready
//   s_axis modport  - consumer side: mirror of m_axis

package dpe_pkg;
    localparam int ADDR_W = 3;
    typedef logic [ADDR_W-1:0] dpe_addr_t;

    localparam dpe_addr_t DPE_ADDR_CPU   = 3'd6;
    localparam dpe_addr_t DPE_ADDR_ETH_1 = 3'd1;
    localparam dpe_addr_t DPE_ADDR_ETH_2 = 3'd2;
    localparam dpe_addr_t DPE_ADDR_ETH_3 = 3'd3;
    localparam dpe_addr_t DPE_ADDR_ETH_4 = 3'd4;
endpackage

interface dpe_if #(
    parameter int DATA_W = 128
) (
    input logic clk,
    input logic rst
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_W-1:0]       tdata;
    logic [DATA_W/8-1:0]     tkeep;
    logic                    tlast;
    logic                    tuser_bypass_all;
    logic                    tuser_bypass_stage;
    dpe_pkg::dpe_addr_t      tuser_src;
    dpe_pkg::dpe_addr_t      tuser_dst;

    modport m_axis (
        input  clk, rst, tready,
        output tvalid, tdata, tkeep, tlast,
               tuser_bypass_all, tuser_bypass_stage, tuser_src, tuser_dst
    );

    modport s_axis (
        input  clk, rst, tvalid, tdata, tkeep, tlast,
               tuser_bypass_all, tuser_bypass_stage, tuser_src, tuser_dst,
        output tready
    );
endinterface

// File: rtl/dpe_input_arbiter.sv
// dpe_input_arbiter
// Purpose: packet-atomic round-robin merge of N_PORTS ingress streams into one
//          dpe_if stream. tuser_src is stamped with the source port address;
//          all other sideband is passed through. Packets never interleave.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   s_tvalid / s_tready   - per-port beat handshake
//   s_tdata / s_tkeep     - per-port data and byte enables
//   s_tlast               - per-port end of packet
//   s_tuser_bypass_all    - per-port bypass flags
//   s_tuser_bypass_stage
//   s_tuser_dst           - per-port requested destination
//   outp                  - merged output stream (registered, 2-entry skid)
//
// state | meaning
// IDLE  | no grant held; arbitrate among requesting ports
// LOCK  | port gnt_q owns the output until its tlast beat is accepted

module dpe_input_arbiter #(
    parameter int N_PORTS = 5,
    parameter int DATA_W  = 128
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [N_PORTS-1:0]                         s_tvalid,
    output logic [N_PORTS-1:0]                         s_tready,
    input  logic [N_PORTS-1:0][DATA_W-1:0]             s_tdata,
    input  logic [N_PORTS-1:0][DATA_W/8-1:0]           s_tkeep,
    input  logic [N_PORTS-1:0]                         s_tlast,
    input  logic [N_PORTS-1:0]                         s_tuser_bypass_all,
    input  logic [N_PORTS-1:0]                         s_tuser_bypass_stage,
    input  logic [N_PORTS-1:0][dpe_pkg::ADDR_W-1:0]    s_tuser_dst,
    dpe_if.m_axis                                      outp
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] keep;
        logic                last;
        logic                bypass_all;
        logic                bypass_stage;
        dpe_pkg::dpe_addr_t  src;
        dpe_pkg::dpe_addr_t  dst;
    } beat_t;

    // Returns {found, index} of the first requester after 'last', wrapping.
    // Scanning from the farthest candidate down lets the nearest one win.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_PORTS-1:0] req,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int i = N_PORTS; i >= 1; i--) begin
            idx = (int'(last) + i) % N_PORTS;
            if (req[idx]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    function automatic dpe_pkg::dpe_addr_t port_addr(input logic [IDX_W-1:0] idx);
        case (int'(idx))
            1:       return dpe_pkg::DPE_ADDR_ETH_1;
            2:       return dpe_pkg::DPE_ADDR_ETH_2;
            3:       return dpe_pkg::DPE_ADDR_ETH_3;
            4:       return dpe_pkg::DPE_ADDR_ETH_4;
            default: return dpe_pkg::DPE_ADDR_CPU;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [1:0]       count_q, count_d;
    logic             out_vld_q, out_vld_d;
    beat_t            head_q, head_d;
    beat_t            skid_q, skid_d;

    logic [IDX_W:0]   pick;
    logic             full;
    logic             accept;
    logic             pop;
    beat_t            in_beat;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        s_tready = '0;
        full     = (count_q == 2'd2);
        accept   = 1'b0;
        pick     = rr_pick(s_tvalid, last_q);

        in_beat.data         = s_tdata[gnt_q];
        in_beat.keep         = s_tkeep[gnt_q];
        in_beat.last         = s_tlast[gnt_q];
        in_beat.bypass_all   = s_tuser_bypass_all[gnt_q];
        in_beat.bypass_stage = s_tuser_bypass_stage[gnt_q];
        in_beat.src          = port_addr(gnt_q);
        in_beat.dst          = s_tuser_dst[gnt_q];

        case (state_q)
            IDLE: begin
                if (pick[IDX_W]) begin
                    state_d = LOCK;
                    gnt_d   = pick[IDX_W-1:0];
                    last_d  = pick[IDX_W-1:0];
                end
            end
            LOCK: begin
                s_tready[gnt_q] = ~full;
                accept          = s_tvalid[gnt_q] & ~full;
                if (accept & s_tlast[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pop = out_vld_q & outp.tready;

        // head_q is the beat on outp; skid_q holds the second entry.
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        case ({accept, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = in_beat;
                end else begin
                    skid_d = in_beat;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = skid_q;
                count_d = count_q - 2'd1;
            end
            // accept is blocked when full, so here exactly one entry is held
            // and it leaves as the new beat replaces it.
            2'b11: begin
                head_d = in_beat;
            end
            default: ;
        endcase
        out_vld_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= IDX_W'(N_PORTS - 1);
            count_q   <= 2'd0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
        end
        head_q <= head_d;
        skid_q <= skid_d;
    end

    assign outp.tvalid             = out_vld_q;
    assign outp.tdata              = head_q.data;
    assign outp.tkeep              = head_q.keep;
    assign outp.tlast              = head_q.last;
    assign outp.tuser_bypass_all   = head_q.bypass_all;
    assign outp.tuser_bypass_stage = head_q.bypass_stage;
    assign outp.tuser_src          = head_q.src;
    assign outp.tuser_dst          = head_q.dst;

endmodule

// File: tb/tb_dpe_input_arbiter.sv
module tb_dpe_input_arbiter;
    import dpe_pkg::*;

    localparam int N  = 5;
    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int AW = ADDR_W;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          ba;
        logic          bs;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]          s_tvalid = '0;
    logic [N-1:0]          s_tready;
    logic [N-1:0][DW-1:0]  s_tdata  = '0;
    logic [N-1:0][KW-1:0]  s_tkeep  = '0;
    logic [N-1:0]          s_tlast  = '0;
    logic [N-1:0]          s_ba     = '0;
    logic [N-1:0]          s_bs     = '0;
    logic [N-1:0][AW-1:0]  s_dst    = '0;

    dpe_if #(.DATA_W(DW)) outp_if (.clk(clk), .rst(rst));

    dpe_input_arbiter #(.N_PORTS(N), .DATA_W(DW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_tvalid             (s_tvalid),
        .s_tready             (s_tready),
        .s_tdata              (s_tdata),
        .s_tkeep              (s_tkeep),
        .s_tlast              (s_tlast),
        .s_tuser_bypass_all   (s_ba),
        .s_tuser_bypass_stage (s_bs),
        .s_tuser_dst          (s_dst),
        .outp                 (outp_if)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t       sb[$];
    int unsigned pop_cyc[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        rand_mode = 1'b0;
    logic        rdy_fixed = 1'b1;

    // monitor state
    beat_t got, prev_beat, exp_b;
    logic  prev_stall = 1'b0;
    int    occ = 0;
    int    max_occ = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: actual=timeout expected=event", name);
    endtask

    function automatic logic [AW-1:0] paddr(input int p);
        case (p)
            0:       return DPE_ADDR_CPU;
            1:       return DPE_ADDR_ETH_1;
            2:       return DPE_ADDR_ETH_2;
            3:       return DPE_ADDR_ETH_3;
            4:       return DPE_ADDR_ETH_4;
            default: return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] bdata(input int p, input int k, input int b);
        return {32'(p), 32'(k), 32'(b), 32'hC0DE0000 + 32'(p * 4096 + k * 16 + b)};
    endfunction

    function automatic logic [KW-1:0] bkeep(input int b);
        return 16'hFFFF >> (b % 4);
    endfunction

    task automatic exp_pkt(input int p, input int k, input int nb,
                           input logic ba, input logic bs, input logic [AW-1:0] dst);
        beat_t e;
        for (int b = 0; b < nb; b++) begin
            e.data = bdata(p, k, b);
            e.keep = bkeep(b);
            e.last = (b == nb - 1);
            e.ba   = ba;
            e.bs   = bs;
            e.src  = paddr(p);
            e.dst  = dst;
            sb.push_back(e);
        end
    endtask

    // Returns at posedge+1 after the edge that accepts port p's current beat.
    task automatic wait_acc(input int p);
        int g;
        g = 0;
        forever begin
            @(negedge clk);
            if (s_tready[p]) break;
            g++;
            if (g > 1000) begin
                fail_now($sformatf("accept_port%0d", p));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int p, input int k, input int nb,
                            input logic ba, input logic bs, input logic [AW-1:0] dst,
                            input int gap_after, input int gap_len);
        for (int b = 0; b < nb; b++) begin
            s_tdata[p]  = bdata(p, k, b);
            s_tkeep[p]  = bkeep(b);
            s_tlast[p]  = (b == nb - 1);
            s_ba[p]     = ba;
            s_bs[p]     = bs;
            s_dst[p]    = dst;
            s_tvalid[p] = 1'b1;
            wait_acc(p);
            if (b == gap_after - 1 && gap_len > 0) begin
                s_tvalid[p] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        s_tvalid[p] = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 160'(outp_if.tvalid), 160'(0));
        check("rst_tready", 160'(s_tready), 160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) fail_now(name);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        outp_if.tready = 1'b1;
        fork
            // output ready driver
            forever begin
                @(posedge clk);
                #2;
                outp_if.tready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
            end

            // monitor / scoreboard
            forever begin
                @(negedge clk);
                got = {outp_if.tdata, outp_if.tkeep, outp_if.tlast,
                       outp_if.tuser_bypass_all, outp_if.tuser_bypass_stage,
                       outp_if.tuser_src, outp_if.tuser_dst};
                if (rst) begin
                    prev_stall = 1'b0;
                    occ        = 0;
                end else begin
                    if (prev_stall) begin
                        check("stall_hold", 160'({outp_if.tvalid, got}), 160'({1'b1, prev_beat}));
                    end
                    if (outp_if.tvalid && outp_if.tready) begin
                        pop_cyc.push_back(cyc);
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL beat_unexpected: actual=%0h expected=none", got);
                        end else begin
                            exp_b = sb.pop_front();
                            check("beat", 160'(got), 160'(exp_b));
                        end
                    end
                    prev_stall = outp_if.tvalid & ~outp_if.tready;
                    prev_beat  = got;
                    occ = occ + int'(|(s_tvalid & s_tready))
                              - int'(outp_if.tvalid & outp_if.tready);
                    if (occ > max_occ) max_occ = occ;
                end
            end

            // stimulus
            begin
                int unsigned t0;
                int          g, viol;
                logic        done;

                do_reset();

                // single port, latency and consecutive beats
                pop_cyc.delete();
                exp_pkt(0, 0, 3, 1'b0, 1'b0, DPE_ADDR_ETH_2);
                t0 = cyc;
                send_pkt(0, 0, 3, 1'b0, 1'b0, DPE_ADDR_ETH_2, 0, 0);
                wait_drain("drain_single");
                check("single_npop", 160'(pop_cyc.size()), 160'(3));
                if (pop_cyc.size() == 3) begin
                    check("single_lat0", 160'(pop_cyc[0]), 160'(t0 + 2));
                    check("single_lat1", 160'(pop_cyc[1]), 160'(t0 + 3));
                    check("single_lat2", 160'(pop_cyc[2]), 160'(t0 + 4));
                end

                // contention from reset: two rounds of 0..4
                do_reset();
                for (int r = 0; r < 2; r++)
                    for (int p = 0; p < N; p++)
                        exp_pkt(p, r, 1, 1'b0, 1'b0, paddr((p + 1) % N));
                fork
                    begin send_pkt(0, 0, 1, 1'b0, 1'b0, paddr(1), 0, 0); send_pkt(0, 1, 1, 1'b0, 1'b0, paddr(1), 0, 0); end
                    begin send_pkt(1, 0, 1, 1'b0, 1'b0, paddr(2), 0, 0); send_pkt(1, 1, 1, 1'b0, 1'b0, paddr(2), 0, 0); end
                    begin send_pkt(2, 0, 1, 1'b0, 1'b0, paddr(3), 0, 0); send_pkt(2, 1, 1, 1'b0, 1'b0, paddr(3), 0, 0); end
                    begin send_pkt(3, 0, 1, 1'b0, 1'b0, paddr(4), 0, 0); send_pkt(3, 1, 1, 1'b0, 1'b0, paddr(4), 0, 0); end
                    begin send_pkt(4, 0, 1, 1'b0, 1'b0, paddr(0), 0, 0); send_pkt(4, 1, 1, 1'b0, 1'b0, paddr(0), 0, 0); end
                join
                wait_drain("drain_contention");

                // atomicity: ETH_1 with a gap, ETH_2 waiting
                do_reset();
                exp_pkt(1, 0, 4, 1'b0, 1'b1, DPE_ADDR_CPU);
                exp_pkt(2, 0, 2, 1'b0, 1'b0, DPE_ADDR_ETH_3);
                fork
                    send_pkt(1, 0, 4, 1'b0, 1'b1, DPE_ADDR_CPU, 2, 3);
                    send_pkt(2, 0, 2, 1'b0, 1'b0, DPE_ADDR_ETH_3, 0, 0);
                    begin
                        g    = 0;
                        viol = 0;
                        done = 1'b0;
                        while (!done && g < 300) begin
                            @(negedge clk);
                            g++;
                            if (s_tready[2] !== 1'b0) viol++;
                            if (s_tvalid[1] && s_tready[1] && s_tlast[1]) done = 1'b1;
                        end
                        check("atom_tlast_seen", 160'(done), 160'(1));
                        check("atom_tready2_low", 160'(viol), 160'(0));
                    end
                join
                wait_drain("drain_atomic");

                // passthrough of sideband on ETH_3
                exp_pkt(3, 0, 2, 1'b1, 1'b0, DPE_ADDR_ETH_4);
                exp_pkt(3, 1, 1, 1'b0, 1'b1, DPE_ADDR_CPU);
                send_pkt(3, 0, 2, 1'b1, 1'b0, DPE_ADDR_ETH_4, 0, 0);
                send_pkt(3, 1, 1, 1'b0, 1'b1, DPE_ADDR_CPU, 0, 0);
                wait_drain("drain_pass");

                // random backpressure, ports 0/2/4 always requesting
                do_reset();
                max_occ   = 0;
                rand_mode = 1'b1;
                for (int k = 0; k < 28; k++)
                    for (int p = 0; p < N; p += 2)
                        exp_pkt(p, k, (k % 4) + 1, 1'(k & 1), 1'((k >> 1) & 1), paddr((p + k) % N));
                fork
                    for (int k = 0; k < 28; k++) send_pkt(0, k, (k % 4) + 1, 1'(k & 1), 1'((k >> 1) & 1), paddr((0 + k) % N), 0, 0);
                    for (int k = 0; k < 28; k++) send_pkt(2, k, (k % 4) + 1, 1'(k & 1), 1'((k >> 1) & 1), paddr((2 + k) % N), 0, 0);
                    for (int k = 0; k < 28; k++) send_pkt(4, k, (k % 4) + 1, 1'(k & 1), 1'((k >> 1) & 1), paddr((4 + k) % N), 0, 0);
                join
                wait_drain("drain_bp");
                rand_mode = 1'b0;
                check("bp_max_occ", 160'(max_occ <= 2), 160'(1));

                // reset mid-packet, then port 0 must win again
                do_reset();
                rdy_fixed  = 1'b0;
                s_tdata[0] = bdata(0, 9, 0);
                s_tkeep[0] = bkeep(0);
                s_tlast[0] = 1'b0;
                s_dst[0]   = DPE_ADDR_ETH_1;
                s_tvalid[0] = 1'b1;
                wait_acc(0);
                s_tdata[0] = bdata(0, 9, 1);
                s_tkeep[0] = bkeep(1);
                rst = 1'b1;
                @(negedge clk);
                check("prerst_tvalid", 160'(outp_if.tvalid), 160'(1));
                @(posedge clk);
                #1;
                rst      = 1'b0;
                s_tvalid = '0;
                @(negedge clk);
                check("midrst_tvalid", 160'(outp_if.tvalid), 160'(0));
                check("midrst_tready", 160'(s_tready), 160'(0));
                @(posedge clk);
                #1;
                rdy_fixed = 1'b1;
                exp_pkt(0, 1, 1, 1'b0, 1'b0, DPE_ADDR_ETH_3);
                exp_pkt(3, 2, 1, 1'b0, 1'b0, DPE_ADDR_CPU);
                fork
                    send_pkt(0, 1, 1, 1'b0, 1'b0, DPE_ADDR_ETH_3, 0, 0);
                    send_pkt(3, 2, 1, 1'b0, 1'b0, DPE_ADDR_CPU, 0, 0);
                join
                wait_drain("drain_rst");

                check("sb_empty", 160'(sb.size()), 160'(0));
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        join
    end

endmodule
